// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//
// Four-requester round-robin arbiter driving the select of a shared 4:1 mux.
// A grant is held for a complete burst (terminated by a last-flagged beat that
// is accepted downstream), so bursts from different requesters never
// interleave. The downstream side is a plain valid/ready handshake.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   req[3:0]      requester i presents a beat on d<i>
//   last[3:0]     current beat of requester i ends its burst
//   d0..d3        requester data, WIDTH bits each
//   y_ready       downstream accepts the beat this cycle
//   y             shared output data (zero when not valid)
//   y_valid       y holds a valid beat
//   y_last        current output beat ends the burst
//   ack[3:0]      requester i's beat is transferred this cycle
//   gnt[3:0]      registered one-hot grant, zero when idle
//   sel[1:0]      registered mux select (index of granted requester)
//
// State table:
//   S_IDLE | no grant; arbitrate among req starting at r_ptr
//   S_BUSY | grant locked to r_sel until its last beat transfers
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [3:0]       last,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             y_last,
    output logic [3:0]       ack,
    output logic [3:0]       gnt,
    output logic [1:0]       sel
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [3:0]       r_gnt;

    logic             w_found;
    logic [1:0]       w_winner;
    logic [1:0]       w_idx;
    logic [WIDTH-1:0] w_data;
    logic             w_busy;
    logic             w_valid;
    logic             w_xfer;

    // Round-robin search: walk offsets from 3 down to 0 so that the smallest
    // offset from r_ptr with a pending request is the one left standing.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_data = '0;
        case (r_sel)
            2'd0:    w_data = d0;
            2'd1:    w_data = d1;
            2'd2:    w_data = d2;
            default: w_data = d3;
        endcase
    end

    assign w_busy  = (r_state == S_BUSY);
    // A granted requester that drops req simply produces a bubble; the grant
    // stays locked.
    assign w_valid = w_busy & req[r_sel];
    assign w_xfer  = w_valid & y_ready;

    assign y_valid = w_valid;
    assign y       = w_valid ? w_data : '0;
    assign y_last  = w_valid & last[r_sel];
    assign ack     = w_xfer ? (4'b0001 << r_sel) : 4'b0000;
    assign gnt     = r_gnt;
    assign sel     = r_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_winner;
                        r_gnt   <= 4'b0001 << w_winner;
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    // Returning to IDLE on the final beat gives the mandatory
                    // one-cycle bubble before the next grant.
                    if (w_xfer && last[r_sel]) begin
                        r_state <= S_IDLE;
                        r_gnt   <= 4'b0000;
                        r_ptr   <= r_sel + 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    localparam int W = 12;
    localparam logic [W-1:0] D0 = 12'h5A5;
    localparam logic [W-1:0] D1 = 12'hA5A;
    localparam logic [W-1:0] D2 = 12'hABC;
    localparam logic [W-1:0] D3 = 12'h3C3;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req;
    logic [3:0]   last;
    logic [W-1:0] d0, d1, d2, d3;
    logic         y_ready;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_last;
    logic [3:0]   ack;
    logic [3:0]   gnt;
    logic [1:0]   sel;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   last;
        logic         rdy;
        logic [3:0]   e_gnt;
        logic [1:0]   e_sel;
        logic         e_yv;
        logic [W-1:0] e_y;
        logic         e_yl;
        logic [3:0]   e_ack;
    } vec_t;

    vec_t vq[$];

    rr_mux_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .last    (last),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .y_ready (y_ready),
        .y       (y),
        .y_valid (y_valid),
        .y_last  (y_last),
        .ack     (ack),
        .gnt     (gnt),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic rd,
                       input logic [3:0] g, input logic [1:0] s, input logic yv,
                       input logic [W-1:0] yy, input logic yl, input logic [3:0] a);
        vec_t v;
        v.req = r; v.last = l; v.rdy = rd;
        v.e_gnt = g; v.e_sel = s; v.e_yv = yv; v.e_y = yy; v.e_yl = yl; v.e_ack = a;
        vq.push_back(v);
    endtask

    task automatic chk_all(input int idx, input logic [3:0] g, input logic [1:0] s, input logic yv,
                           input logic [W-1:0] yy, input logic yl, input logic [3:0] a);
        chk("gnt", idx, 32'(gnt), 32'(g));
        chk("sel", idx, 32'(sel), 32'(s));
        chk("y_valid", idx, 32'(y_valid), 32'(yv));
        chk("y", idx, 32'(y), 32'(yy));
        chk("y_last", idx, 32'(y_last), 32'(yl));
        chk("ack", idx, 32'(ack), 32'(a));
    endtask

    // Structural invariants, sampled mid-cycle while out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("gnt_onehot0", -1, 32'($onehot0(gnt)), 32'(1));
            chk("ack_onehot0", -1, 32'($onehot0(ack)), 32'(1));
            if (gnt != 4'b0000)
                chk("gnt_vs_sel", -1, 32'(gnt), 32'(4'b0001 << sel));
        end
    end

    initial begin
        d0 = D0; d1 = D1; d2 = D2; d3 = D3;
        reset_n = 1'b0; req = 4'b1111; last = 4'b0000; y_ready = 1'b1;

        // idle after reset, req low
        repeat (5) add(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        // single requester 2, single-beat burst; then prove ptr moved to 3
        add(4'b0100, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, D2, 1'b1, 4'b0100);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1100, 4'b1111, 1'b0, 4'b0000, 2'd2, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1100, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, D3, 1'b1, 4'b1000);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, '0, 1'b0, 4'b0000);
        // round robin, all requesting, single-beat bursts, ptr=0
        add(4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, D0, 1'b1, 4'b0001);
        add(4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, D1, 1'b1, 4'b0010);
        add(4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, D2, 1'b1, 4'b0100);
        add(4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, D3, 1'b1, 4'b1000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, D0, 1'b1, 4'b0001);
        // burst lock on requester 1: 3 beats, ready 1,0,1,1 and a req gap
        add(4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1111, 4'b1101, 1'b1, 4'b0010, 2'd1, 1'b1, D1, 1'b0, 4'b0010);
        add(4'b1111, 4'b1101, 1'b0, 4'b0010, 2'd1, 1'b1, D1, 1'b0, 4'b0000);
        add(4'b1101, 4'b1101, 1'b1, 4'b0010, 2'd1, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1111, 4'b1101, 1'b1, 4'b0010, 2'd1, 1'b1, D1, 1'b0, 4'b0010);
        add(4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, D1, 1'b1, 4'b0010);
        add(4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, D2, 1'b1, 4'b0100);
        // backpressure on requester 3
        add(4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, '0, 1'b0, 4'b0000);
        repeat (4) add(4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, D3, 1'b0, 4'b0000);
        add(4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, D3, 1'b0, 4'b1000);
        add(4'b1000, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, D3, 1'b1, 4'b1000);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, '0, 1'b0, 4'b0000);
        // requester 0 single burst (ptr -> 1), then a multi-beat burst to be cut
        add(4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd3, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, D0, 1'b1, 4'b0001);
        add(4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        add(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, D0, 1'b0, 4'b0001);
        add(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, D0, 1'b0, 4'b0001);

        // reset held with requests pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all(-10, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        req = 4'b0000;
        #1 reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            req = vq[i].req; last = vq[i].last; y_ready = vq[i].rdy;
            @(negedge clk);
            chk_all(i, vq[i].e_gnt, vq[i].e_sel, vq[i].e_yv, vq[i].e_y, vq[i].e_yl, vq[i].e_ack);
        end

        // mid-burst reset pulse (beat 2 of requester 0) lasting half a cycle
        #1 reset_n = 1'b0;
        #1;
        chk_all(-20, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req = 4'b0011; last = 4'b0011; y_ready = 1'b1;
        @(negedge clk);
        chk_all(-21, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all(-22, 4'b0001, 2'd0, 1'b1, D0, 1'b1, 4'b0001);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all(-23, 4'b0000, 2'd0, 1'b0, '0, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_all(-24, 4'b0010, 2'd1, 1'b1, D1, 1'b1, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
